// File: rtl/chunked_serial_adder.sv
// Multi-cycle ripple-carry adder: WIDTH-bit operands summed CHUNK bits per clock.
// Optional subtract mode (a + ~b + 1) enabled by defining ADDER_SUB_EN.
module chunked_serial_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4    // must divide WIDTH exactly
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
`ifdef ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] op_a, op_b, acc, acc_next;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic             sub_sel;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_cin;

`ifdef ADDER_SUB_EN
    assign sub_sel = sub;
`else
    assign sub_sel = 1'b0;
`endif

    // Operands shift right so the active chunk always sits in the low CHUNK bits;
    // partial sums enter acc from the top so it is fully aligned after N steps.
    always_comb begin
        chunk_sum = {1'b0, op_a[CHUNK-1:0]} + {1'b0, op_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry};
        acc_next  = (acc >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));
        msb_cin   = op_a[CHUNK-1] ^ op_b[CHUNK-1] ^ chunk_sum[CHUNK-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a  <= a;
                        // Subtraction folds into the add path: invert b, force carry-in to 1.
                        op_b  <= sub_sel ? ~b : b;
                        carry <= sub_sel ? 1'b1 : carry_in;
                        idx   <= '0;
                        busy  <= 1'b1;
                        state <= BUSY;
                    end else begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    op_a  <= op_a >> CHUNK;
                    op_b  <= op_b >> CHUNK;
                    carry <= chunk_sum[CHUNK];
                    acc   <= acc_next;
                    idx   <= idx + 1'b1;
                    if (idx == IDX_W'(N - 1)) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        sum       <= acc_next;
                        carry_out <= chunk_sum[CHUNK];
                        overflow  <= msb_cin ^ chunk_sum[CHUNK];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
